// File: rtl/noc_router_rr_pkg.sv
// noc_router_pkg: port indices, arbiter state type and the XY routing helper
// shared by the noc_router_rr mesh router files.
package noc_router_pkg;

  localparam int unsigned PORT_NI = 0;
  localparam int unsigned PORT_E  = 1;
  localparam int unsigned PORT_W  = 2;
  localparam int unsigned PORT_N  = 3;
  localparam int unsigned PORT_S  = 4;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Dimension-ordered route: resolve X first, then Y; unsigned compares.
  // Coordinates are zero-extended to 16 bits by the caller.
  function automatic logic [2:0] xy_route(input logic [15:0] dst_x, input logic [15:0] dst_y,
                                          input logic [15:0] my_x, input logic [15:0] my_y);
    logic [2:0] port;
    if (dst_x > my_x)      port = 3'(PORT_E);
    else if (dst_x < my_x) port = 3'(PORT_W);
    else if (dst_y > my_y) port = 3'(PORT_N);
    else if (dst_y < my_y) port = 3'(PORT_S);
    else                   port = 3'(PORT_NI);
    return port;
  endfunction

endpackage

// File: rtl/noc_router_rr_if.sv
// noc_router_rr_if: flattened ingress/egress flit buses of the router.
// slave = router side, master = traffic source/sink side.
interface noc_router_rr_if #(
  parameter int unsigned NP         = 5,
  parameter int unsigned PORT_WIDTH = 32
);
  logic [NP*PORT_WIDTH-1:0] in_tdata;
  logic [NP-1:0]            in_tvalid;
  logic [NP-1:0]            in_tlast;
  logic [NP-1:0]            in_tready;
  logic [NP*PORT_WIDTH-1:0] out_tdata;
  logic [NP-1:0]            out_tvalid;
  logic [NP-1:0]            out_tlast;
  logic [NP-1:0]            out_tready;

  modport master (
    output in_tdata, in_tvalid, in_tlast, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast
  );

  modport slave (
    input  in_tdata, in_tvalid, in_tlast, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/noc_router_rr_arbiter.sv
// noc_rr_arbiter: per-output round-robin arbiter. Grants a header-carrying
// input and stays locked to it until the tail flit handshakes.
module noc_rr_arbiter
  import noc_router_pkg::*;
#(
  parameter int unsigned NP = 5,
  parameter int unsigned PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NP-1:0] req,
  input  logic [NP-1:0] nonempty,
  input  logic [NP-1:0] head_last,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [PW-1:0] sel
);
  arb_state_t    state, state_n;
  logic [PW-1:0] owner, owner_n;
  logic [PW-1:0] rr_ptr, rr_n;
  logic [PW-1:0] sel_inc;
  int unsigned   idx;

  // state register: FSM state, locked owner and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      rr_ptr <= rr_n;
    end
  end

  // next state: lock on a multi-flit header, release on its tail
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr_ptr;
    sel_inc = (sel == PW'(NP - 1)) ? '0 : sel + PW'(1);
    if (out_valid && out_ready) begin
      if (state == ARB_IDLE) begin
        rr_n = sel_inc;
        if (!head_last[sel]) begin
          state_n = ARB_BUSY;
          owner_n = sel;
        end
      end else if (head_last[sel]) begin
        state_n = ARB_IDLE;
      end
    end
  end

  // outputs: locked owner when busy, else first request at or after rr_ptr
  always_comb begin
    out_valid = 1'b0;
    sel       = owner;
    idx       = 0;
    if (state == ARB_BUSY) begin
      out_valid = nonempty[owner];
    end else begin
      for (int unsigned k = 0; k < NP; k++) begin
        idx = (32'(rr_ptr) + k) % NP;
        if (!out_valid && req[idx]) begin
          out_valid = 1'b1;
          sel       = PW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/noc_router_rr.sv
// noc_router_rr: wormhole XY router, port 0 = NI, 1..NUM_PORTS = E,W,N,S.
// Per-input FIFO, per-output round-robin arbiter locked for a whole packet.
// Optional build macro ROUTER_DROP_CORRUPT_EN: headers carry even parity in
// the MSB; packets with a bad header are drained and counted in drop_cnt.
module noc_router_rr
  import noc_router_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned PORT_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned MY_X       = 0,
  parameter int unsigned MY_Y       = 0
) (
  input logic            clk,
  input logic            rst_n,
  noc_router_rr_if.slave bus
);
  localparam int unsigned NP = NUM_PORTS + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = $clog2(NP);

  logic [PORT_WIDTH:0]   mem [NP][FIFO_DEPTH];
  logic [AW:0]           wr_ptr [NP];
  logic [AW:0]           rd_ptr [NP];
  logic [PORT_WIDTH-1:0] head_data [NP];
  logic [2:0]            xy_port [NP];
  logic [PW-1:0]         route [NP];
  logic [NP-1:0]         req [NP];
  logic [PW-1:0]         a_sel [NP];
  logic [NP-1:0]         empty, full, push, pop, hdr, head_last;
  logic [NP-1:0]         rerr, bad, hdr_ok, drop_pop, a_valid;
  logic                  ready_en, route_err;

  // FIFO status and head flit; wrap bit distinguishes full from empty
  always_comb begin
    for (int unsigned i = 0; i < NP; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) && (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      {head_last[i], head_data[i]} = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  assign bus.in_tready = {NP{ready_en}} & ~full;
  assign push          = bus.in_tvalid & {NP{ready_en}} & ~full;

  // XY route of each head header; unreachable or U-turn routes fall back to NI
  always_comb begin
    for (int unsigned i = 0; i < NP; i++) begin
      xy_port[i] = xy_route(16'(head_data[i][2*COORD_W-1:COORD_W]), 16'(head_data[i][COORD_W-1:0]),
                            16'(MY_X), 16'(MY_Y));
      rerr[i]    = (xy_port[i] > 3'(NUM_PORTS)) || (xy_port[i] == 3'(i));
      route[i]   = rerr[i] ? PW'(PORT_NI) : PW'(xy_port[i]);
      hdr_ok[i]  = !empty[i] && hdr[i] && !bad[i];
    end
    // A header at the head means the input is not mid-packet, so no input
    // already locked to an output can request here.
    for (int unsigned o = 0; o < NP; o++) begin
      for (int unsigned i = 0; i < NP; i++) begin
        req[o][i] = hdr_ok[i] && (route[i] == PW'(o));
      end
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    noc_rr_arbiter #(.NP(NP), .PW(PW)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req[o]),
      .nonempty  (~empty),
      .head_last (head_last),
      .out_ready (bus.out_tready[o]),
      .out_valid (a_valid[o]),
      .sel       (a_sel[o])
    );
  end

  assign bus.out_tvalid = a_valid;

  // egress mux and FIFO pop from the input each output is serving
  always_comb begin
    pop           = drop_pop;
    bus.out_tdata = '0;
    bus.out_tlast = '0;
    for (int unsigned o = 0; o < NP; o++) begin
      if (a_valid[o]) begin
        bus.out_tdata[o*PORT_WIDTH +: PORT_WIDTH] = head_data[a_sel[o]];
        bus.out_tlast[o]                          = head_last[a_sel[o]];
      end
      for (int unsigned i = 0; i < NP; i++) begin
        if (a_valid[o] && bus.out_tready[o] && (a_sel[o] == PW'(i))) pop[i] = 1'b1;
      end
    end
  end

  // FIFO pointers, header tracking, ingress enable and sticky route error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      route_err <= 1'b0;
      hdr       <= '1;
      for (int unsigned i = 0; i < NP; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      ready_en <= 1'b1;
      if (|(hdr_ok & rerr)) route_err <= 1'b1;
      for (int unsigned i = 0; i < NP; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
          hdr[i]    <= head_last[i];
        end
      end
    end
  end

  // FIFO storage, written on the ingress handshake
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NP; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= {bus.in_tlast[i], bus.in_tdata[i*PORT_WIDTH +: PORT_WIDTH]};
    end
  end

`ifdef ROUTER_DROP_CORRUPT_EN
  logic [NP-1:0] drop_st, drop_start;
  logic [15:0]   drop_cnt, drop_cnt_n;

  // parity check on head headers; a drained packet pops one flit per cycle
  always_comb begin
    drop_cnt_n = drop_cnt;
    for (int unsigned i = 0; i < NP; i++) begin
      bad[i]        = ^head_data[i];
      drop_start[i] = !empty[i] && hdr[i] && bad[i];
      drop_pop[i]   = !empty[i] && (drop_st[i] || drop_start[i]);
      if (drop_start[i] && (drop_cnt_n != '1)) drop_cnt_n = drop_cnt_n + 16'd1;
    end
  end

  // drop state per input and saturating packet-drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_st  <= '0;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_cnt_n;
      for (int unsigned i = 0; i < NP; i++) begin
        if (drop_pop[i]) drop_st[i] <= !head_last[i];
      end
    end
  end
`else
  assign bad      = '0;
  assign drop_pop = '0;
`endif

endmodule

// File: tb/tb_noc_router_rr.sv
// tb_noc_router_rr: directed bench for noc_router_rr at MY=(1,1), one 4-port
// and one 2-port instance sharing clock and reset.
module tb_noc_router_rr;
  import noc_router_pkg::*;

  localparam int unsigned PW = 32;

  logic clk, rst_n;
  int   checks, errors;

  noc_router_rr_if #(.NP(5), .PORT_WIDTH(PW)) bus_a ();
  noc_router_rr_if #(.NP(3), .PORT_WIDTH(PW)) bus_b ();

  noc_router_rr #(.NUM_PORTS(4), .PORT_WIDTH(PW), .FIFO_DEPTH(4), .COORD_W(4), .MY_X(1), .MY_Y(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  noc_router_rr #(.NUM_PORTS(2), .PORT_WIDTH(PW), .FIFO_DEPTH(4), .COORD_W(4), .MY_X(1), .MY_Y(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // header with the parity MSB filled in when the parity feature is built
  function automatic logic [31:0] mk_hdr(input logic [31:0] d);
    logic [31:0] h;
    h = d;
`ifdef ROUTER_DROP_CORRUPT_EN
    h[31] = ^d[30:0];
`endif
    return h;
  endfunction

  function automatic logic [31:0] a_out(input int unsigned p);
    return bus_a.out_tdata[p*PW +: PW];
  endfunction

  task automatic a_drive(input int unsigned p, input logic v, input logic [31:0] d, input logic l);
    bus_a.in_tvalid[p]          = v;
    bus_a.in_tdata[p*PW +: PW]  = d;
    bus_a.in_tlast[p]           = l;
  endtask

  task automatic b_drive(input int unsigned p, input logic v, input logic [31:0] d, input logic l);
    bus_b.in_tvalid[p]          = v;
    bus_b.in_tdata[p*PW +: PW]  = d;
    bus_b.in_tlast[p]           = l;
  endtask

  task automatic idle_all();
    bus_a.in_tvalid = '0; bus_a.in_tdata = '0; bus_a.in_tlast = '0; bus_a.out_tready = '1;
    bus_b.in_tvalid = '0; bus_b.in_tdata = '0; bus_b.in_tlast = '0; bus_b.out_tready = '1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus_a.in_tready !== 5'b00000) begin errors++; $display("FAIL reset_in_tready: got %b expected 00000", bus_a.in_tready); end
    checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL reset_out_tvalid: got %b expected 00000", bus_a.out_tvalid); end
    checks++; if (bus_a.out_tdata !== '0) begin errors++; $display("FAIL reset_out_tdata: got %h expected 0", bus_a.out_tdata); end
    checks++; if (bus_a.out_tlast !== 5'b00000) begin errors++; $display("FAIL reset_out_tlast: got %b expected 00000", bus_a.out_tlast); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus_a.in_tready !== 5'b00000) begin errors++; $display("FAIL ready_at_release: got %b expected 00000", bus_a.in_tready); end
    @(negedge clk); #1;
    checks++; if (bus_a.in_tready !== 5'b11111) begin errors++; $display("FAIL ready_after_release: got %b expected 11111", bus_a.in_tready); end
    checks++; if (bus_b.in_tready !== 3'b111) begin errors++; $display("FAIL ready_b_after_release: got %b expected 111", bus_b.in_tready); end
    checks++; if (dut_a.g_out[1].u_arb.rr_ptr !== 3'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut_a.g_out[1].u_arb.rr_ptr); end
    checks++; if (dut_a.route_err !== 1'b0) begin errors++; $display("FAIL reset_route_err: got %b expected 0", dut_a.route_err); end
  endtask

  task automatic test_single_flit();
    logic [31:0] h1, h2;
    h1 = mk_hdr(32'h2000_0021);
    h2 = mk_hdr(32'h2000_0011);
    @(negedge clk); a_drive(2, 1'b1, h1, 1'b1); #1;
    checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL sf_no_bypass: got %b expected 00000", bus_a.out_tvalid); end
    @(negedge clk); a_drive(2, 1'b0, '0, 1'b0); #1;
    checks++; if (bus_a.out_tvalid !== 5'b00010) begin errors++; $display("FAIL sf_e_valid: got %b expected 00010", bus_a.out_tvalid); end
    checks++; if (a_out(1) !== h1) begin errors++; $display("FAIL sf_e_data: got %h expected %h", a_out(1), h1); end
    checks++; if (bus_a.out_tlast[1] !== 1'b1) begin errors++; $display("FAIL sf_e_last: got %b expected 1", bus_a.out_tlast[1]); end
    @(negedge clk); a_drive(2, 1'b1, h2, 1'b1); #1;
    checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL sf_e_gone: got %b expected 00000", bus_a.out_tvalid); end
    @(negedge clk); a_drive(2, 1'b0, '0, 1'b0); #1;
    checks++; if (bus_a.out_tvalid !== 5'b00001) begin errors++; $display("FAIL sf_ni_valid: got %b expected 00001", bus_a.out_tvalid); end
    checks++; if (a_out(0) !== h2) begin errors++; $display("FAIL sf_ni_data: got %h expected %h", a_out(0), h2); end
    @(negedge clk); #1;
    checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL sf_ni_gone: got %b expected 00000", bus_a.out_tvalid); end
  endtask

  task automatic test_rr_lock();
    logic [31:0] nf [3];
    logic [31:0] sf [3];
    logic [31:0] ex [6];
    nf[0] = mk_hdr(32'h3000_0021); nf[1] = 32'h3333_0001; nf[2] = 32'h3333_0002;
    sf[0] = mk_hdr(32'h4000_0021); sf[1] = 32'h4444_0001; sf[2] = 32'h4444_0002;
    ex[0] = nf[0]; ex[1] = nf[1]; ex[2] = nf[2]; ex[3] = sf[0]; ex[4] = sf[1]; ex[5] = sf[2];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 3) begin
        a_drive(3, 1'b1, nf[c], c == 2);
        a_drive(4, 1'b1, sf[c], c == 2);
      end else begin
        a_drive(3, 1'b0, '0, 1'b0);
        a_drive(4, 1'b0, '0, 1'b0);
      end
      #1;
      if (c < 3) begin
        checks++; if (bus_a.in_tready[4:3] !== 2'b11) begin errors++; $display("FAIL rr_in_ready c%0d: got %b expected 11", c, bus_a.in_tready[4:3]); end
      end
      if (c >= 1 && c <= 6) begin
        checks++; if (bus_a.out_tvalid !== 5'b00010) begin errors++; $display("FAIL rr_valid c%0d: got %b expected 00010", c, bus_a.out_tvalid); end
        checks++; if (a_out(1) !== ex[c-1]) begin errors++; $display("FAIL rr_data c%0d: got %h expected %h", c, a_out(1), ex[c-1]); end
        checks++; if (bus_a.out_tlast[1] !== (c == 3 || c == 6)) begin errors++; $display("FAIL rr_last c%0d: got %b expected %b", c, bus_a.out_tlast[1], (c == 3 || c == 6)); end
      end
      if (c == 2) begin
        checks++; if (dut_a.g_out[1].u_arb.rr_ptr !== 3'd4) begin errors++; $display("FAIL rr_ptr_after_grant: got %0d expected 4", dut_a.g_out[1].u_arb.rr_ptr); end
      end
      if (c == 7) begin
        checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL rr_drained: got %b expected 00000", bus_a.out_tvalid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] f [8];
    int pi, ci;
    f[0] = mk_hdr(32'h5000_0021);
    for (int k = 1; k < 8; k++) f[k] = 32'h5555_0000 + 32'(k);
    pi = 0; ci = 0;
    for (int c = 0; c < 40 && ci < 8; c++) begin
      @(negedge clk);
      if (pi < 8) a_drive(0, 1'b1, f[pi], pi == 7); else a_drive(0, 1'b0, '0, 1'b0);
      bus_a.out_tready[1] = !(c >= 3 && c < 13);
      #1;
      if (c >= 3 && c < 13) begin
        checks++; if ({bus_a.out_tvalid[1], a_out(1)} !== {1'b1, f[2]}) begin errors++; $display("FAIL bp_stable c%0d: got %b/%h expected 1/%h", c, bus_a.out_tvalid[1], a_out(1), f[2]); end
      end
      if (c == 12) begin
        checks++; if (bus_a.in_tready[0] !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", bus_a.in_tready[0]); end
      end
      if (c == 14) begin
        checks++; if (bus_a.in_tready[0] !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b expected 1", bus_a.in_tready[0]); end
      end
      if (bus_a.out_tvalid[1] && bus_a.out_tready[1]) begin
        checks++; if ({bus_a.out_tlast[1], a_out(1)} !== {(ci == 7), f[ci]}) begin errors++; $display("FAIL bp_flit%0d: got %b/%h expected %b/%h", ci, bus_a.out_tlast[1], a_out(1), (ci == 7), f[ci]); end
        ci++;
      end
      if (bus_a.in_tvalid[0] && bus_a.in_tready[0]) pi++;
    end
    checks++; if (ci != 8) begin errors++; $display("FAIL bp_count: got %0d flits expected 8", ci); end
    @(negedge clk); a_drive(0, 1'b0, '0, 1'b0); bus_a.out_tready = '1; #1;
    checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL bp_no_dup: got %b expected 00000", bus_a.out_tvalid); end
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] h;
    h = mk_hdr(32'h6100_0012);
    @(negedge clk); a_drive(2, 1'b1, mk_hdr(32'h6000_0021), 1'b0);
    @(negedge clk); a_drive(2, 1'b1, 32'h6666_0001, 1'b0); #1;
    checks++; if (bus_a.out_tvalid !== 5'b00010) begin errors++; $display("FAIL rm_hdr_valid: got %b expected 00010", bus_a.out_tvalid); end
    @(negedge clk); a_drive(2, 1'b0, '0, 1'b0); #1;
    checks++; if (dut_a.g_out[1].u_arb.state !== ARB_BUSY) begin errors++; $display("FAIL rm_busy: got %0d expected %0d", dut_a.g_out[1].u_arb.state, ARB_BUSY); end
    rst_n = 1'b0; #1;
    checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL rm_valid_in_reset: got %b expected 00000", bus_a.out_tvalid); end
    checks++; if (bus_a.in_tready !== 5'b00000) begin errors++; $display("FAIL rm_ready_in_reset: got %b expected 00000", bus_a.in_tready); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk); a_drive(0, 1'b1, h, 1'b1); #1;
    checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL rm_nothing_left: got %b expected 00000", bus_a.out_tvalid); end
    @(negedge clk); a_drive(0, 1'b0, '0, 1'b0); #1;
    checks++; if (bus_a.out_tvalid !== 5'b01000) begin errors++; $display("FAIL rm_fresh_valid: got %b expected 01000", bus_a.out_tvalid); end
    checks++; if (a_out(3) !== h) begin errors++; $display("FAIL rm_fresh_data: got %h expected %h", a_out(3), h); end
    @(negedge clk); #1;
    checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL rm_fresh_gone: got %b expected 00000", bus_a.out_tvalid); end
  endtask

  task automatic test_route_err();
    logic [31:0] ha, hb;
    ha = mk_hdr(32'h7000_0021);
    hb = mk_hdr(32'h8000_0013);
    checks++; if (dut_a.route_err !== 1'b0) begin errors++; $display("FAIL re_a_clear: got %b expected 0", dut_a.route_err); end
    @(negedge clk); a_drive(1, 1'b1, ha, 1'b1); b_drive(1, 1'b1, hb, 1'b1);
    @(negedge clk); a_drive(1, 1'b0, '0, 1'b0); b_drive(1, 1'b0, '0, 1'b0); #1;
    checks++; if (bus_a.out_tvalid !== 5'b00001) begin errors++; $display("FAIL re_uturn_valid: got %b expected 00001", bus_a.out_tvalid); end
    checks++; if (a_out(0) !== ha) begin errors++; $display("FAIL re_uturn_data: got %h expected %h", a_out(0), ha); end
    checks++; if (bus_b.out_tvalid !== 3'b001) begin errors++; $display("FAIL re_np2_valid: got %b expected 001", bus_b.out_tvalid); end
    checks++; if (bus_b.out_tdata[0 +: PW] !== hb) begin errors++; $display("FAIL re_np2_data: got %h expected %h", bus_b.out_tdata[0 +: PW], hb); end
    @(negedge clk); #1;
    checks++; if (dut_a.route_err !== 1'b1) begin errors++; $display("FAIL re_uturn_flag: got %b expected 1", dut_a.route_err); end
    checks++; if (dut_b.route_err !== 1'b1) begin errors++; $display("FAIL re_np2_flag: got %b expected 1", dut_b.route_err); end
    checks++; if (bus_b.out_tvalid !== 3'b000) begin errors++; $display("FAIL re_np2_gone: got %b expected 000", bus_b.out_tvalid); end
  endtask

`ifdef ROUTER_DROP_CORRUPT_EN
  task automatic test_drop();
    logic [31:0] fl [5];
    fl[0] = mk_hdr(32'h1900_0021) ^ 32'h8000_0000;
    fl[1] = 32'h9999_0001; fl[2] = 32'h9999_0002; fl[3] = 32'h9999_0003;
    fl[4] = mk_hdr(32'h1A00_0021);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 5) a_drive(0, 1'b1, fl[c], c >= 3); else a_drive(0, 1'b0, '0, 1'b0);
      #1;
      if (c == 0) begin
        checks++; if (dut_a.drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_cnt_start: got %0d expected 0", dut_a.drop_cnt); end
      end
      if (c < 5) begin
        checks++; if (bus_a.in_tready[0] !== 1'b1) begin errors++; $display("FAIL drop_ready c%0d: got %b expected 1", c, bus_a.in_tready[0]); end
        checks++; if (bus_a.out_tvalid !== 5'b00000) begin errors++; $display("FAIL drop_silent c%0d: got %b expected 00000", c, bus_a.out_tvalid); end
      end
      if (c == 5) begin
        checks++; if (bus_a.out_tvalid !== 5'b00010) begin errors++; $display("FAIL drop_good_valid: got %b expected 00010", bus_a.out_tvalid); end
        checks++; if (a_out(1) !== fl[4]) begin errors++; $display("FAIL drop_good_data: got %h expected %h", a_out(1), fl[4]); end
        checks++; if (dut_a.drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt: got %0d expected 1", dut_a.drop_cnt); end
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_flit();
    test_rr_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_route_err();
`ifdef ROUTER_DROP_CORRUPT_EN
    test_drop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
